// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the load-use hazard scoreboard.
// Entry rd fields are sized to RD_MAX_W so one struct serves any REG_ADDR_W up to that width.
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int RD_MAX_W       = 8;

    localparam logic [RD_MAX_W-1:0] X0 = '0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/hazard_match.sv
// Compares one IF/ID source operand against every in-flight load in the scoreboard.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_LAT   = 1
) (
    input  logic [REG_ADDR_W-1:0]            rs_addr_i,
    input  logic                             rs_valid_i,
    input  logic [LOAD_LAT*SB_ENTRY_W-1:0]   entries_i,
    output logic                             hit_o
);

    sb_entry_t [LOAD_LAT-1:0] entries;
    logic [RD_MAX_W-1:0]      rs_ext;

    assign entries = entries_i;
    assign rs_ext  = RD_MAX_W'(rs_addr_i);

    // x0 reads never depend on a load, so they are excluded before any compare.
    always_comb begin
        hit_o = 1'b0;
        if (rs_valid_i && (rs_ext != X0)) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                if (entries[i].valid && (entries[i].rd == rs_ext)) begin
                    hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit: tracks loads for LOAD_LAT cycles after EX entry and
// produces stall / bubble / flush controls, with a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          id_memread_i,
    input  logic [REG_ADDR_W-1:0]         id_rd_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ifid_rs_addr_i,
    input  logic [NUM_SRC-1:0]            ifid_rs_valid_i,
    input  logic                          mem_busy_i,
    input  logic                          branch_flush_i,
    output logic                          pc_write_o,
    output logic                          stall_o,
    output logic                          noop_o,
    output logic                          flush_o,
    output logic [CNT_W-1:0]              stall_cnt_o
);

    sb_entry_t [LOAD_LAT-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_SRC-1:0]       hit;
    logic                     hazard;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_match
            hazard_match #(
                .REG_ADDR_W (REG_ADDR_W),
                .LOAD_LAT   (LOAD_LAT)
            ) u_match (
                .rs_addr_i  (ifid_rs_addr_i[gi*REG_ADDR_W +: REG_ADDR_W]),
                .rs_valid_i (ifid_rs_valid_i[gi]),
                .entries_i  (sb_q),
                .hit_o      (hit[gi])
            );
        end
    endgenerate

    assign hazard = |hit;

    // Controls are gated by reset directly so a busy memory cannot stall the
    // pipeline while the unit is held in reset.
    always_comb begin
        pc_write_o = 1'b1;
        stall_o    = 1'b0;
        noop_o     = 1'b0;
        flush_o    = 1'b0;
        if (rst_i) begin
            if (mem_busy_i) begin
                pc_write_o = 1'b0;
                stall_o    = 1'b1;
            end else if (hazard) begin
                pc_write_o = 1'b0;
                stall_o    = 1'b1;
                noop_o     = 1'b1;
            end else if (branch_flush_i) begin
                flush_o    = 1'b1;
            end
        end
    end

    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        if (!mem_busy_i) begin
            for (int i = LOAD_LAT - 1; i >= 1; i--) begin
                sb_d[i] = sb_q[i-1];
            end
            if (hazard) begin
                sb_d[0] = '0;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                sb_d[0].rd    = RD_MAX_W'(id_rd_i);
                sb_d[0].valid = id_memread_i && (RD_MAX_W'(id_rd_i) != X0);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4) share one stimulus stream.
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_memread_i;
    logic [4:0]  id_rd_i;
    logic [9:0]  ifid_rs_addr_i;
    logic [1:0]  ifid_rs_valid_i;
    logic        mem_busy_i;
    logic        branch_flush_i;

    logic        pc_a, st_a, no_a, fl_a;
    logic        pc_b, st_b, no_b, fl_b;
    logic        pc_c, st_c, no_c, fl_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic [3:0]  ctl_a, ctl_b, ctl_c;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] IDLE  = 4'b1000;
    localparam logic [3:0] STALL = 4'b0110;
    localparam logic [3:0] FREEZE = 4'b0100;
    localparam logic [3:0] FLUSH = 4'b1001;

    assign ctl_a = {pc_a, st_a, no_a, fl_a};
    assign ctl_b = {pc_b, st_b, no_b, fl_b};
    assign ctl_c = {pc_c, st_c, no_c, fl_c};

    always #5 clk_i = ~clk_i;

    hazard_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .id_memread_i(id_memread_i), .id_rd_i(id_rd_i),
        .ifid_rs_addr_i(ifid_rs_addr_i), .ifid_rs_valid_i(ifid_rs_valid_i),
        .mem_busy_i(mem_busy_i), .branch_flush_i(branch_flush_i),
        .pc_write_o(pc_a), .stall_o(st_a), .noop_o(no_a), .flush_o(fl_a), .stall_cnt_o(cnt_a)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .id_memread_i(id_memread_i), .id_rd_i(id_rd_i),
        .ifid_rs_addr_i(ifid_rs_addr_i), .ifid_rs_valid_i(ifid_rs_valid_i),
        .mem_busy_i(mem_busy_i), .branch_flush_i(branch_flush_i),
        .pc_write_o(pc_b), .stall_o(st_b), .noop_o(no_b), .flush_o(fl_b), .stall_cnt_o(cnt_b)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)) dut_c (
        .clk_i(clk_i), .rst_i(rst_i), .id_memread_i(id_memread_i), .id_rd_i(id_rd_i),
        .ifid_rs_addr_i(ifid_rs_addr_i), .ifid_rs_valid_i(ifid_rs_valid_i),
        .mem_busy_i(mem_busy_i), .branch_flush_i(branch_flush_i),
        .pc_write_o(pc_c), .stall_o(st_c), .noop_o(no_c), .flush_o(fl_c), .stall_cnt_o(cnt_c)
    );

    task automatic set_idle();
        id_memread_i    = 1'b0;
        id_rd_i         = 5'd0;
        ifid_rs_addr_i  = '0;
        ifid_rs_valid_i = 2'b00;
        mem_busy_i      = 1'b0;
        branch_flush_i  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        set_idle();
        id_memread_i = 1'b1;
        id_rd_i      = rd;
        #1;
    endtask

    task automatic drive_use(input int ch, input logic [4:0] rs, input logic vld);
        set_idle();
        ifid_rs_addr_i[ch*5 +: 5] = rs;
        ifid_rs_valid_i[ch]       = vld;
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_i          = 1'b0;
        mem_busy_i     = 1'b1;
        branch_flush_i = 1'b1;
        #1;
        checks++;
        if (ctl_a !== IDLE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl_a, IDLE); end
        step();
        checks++;
        if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
        checks++;
        if (ctl_b !== IDLE) begin errors++; $display("FAIL reset_ctl_lat3 got=%b exp=%b", ctl_b, IDLE); end
        $display("reset: ctl=%b cnt=%0d", ctl_a, cnt_a);
        rst_i = 1'b1;
        set_idle();
        #1;
    endtask

    task automatic test_lat1();
        do_reset();
        drive_load(5'd5);
        checks++;
        if (ctl_a !== IDLE) begin errors++; $display("FAIL lat1_load_cycle got=%b exp=%b", ctl_a, IDLE); end
        step();
        drive_use(0, 5'd5, 1'b1);
        checks++;
        if (ctl_a !== STALL) begin errors++; $display("FAIL lat1_stall got=%b exp=%b", ctl_a, STALL); end
        step();
        checks++;
        if (ctl_a !== IDLE) begin errors++; $display("FAIL lat1_release got=%b exp=%b", ctl_a, IDLE); end
        checks++;
        if (cnt_a !== 16'd1) begin errors++; $display("FAIL lat1_cnt got=%0d exp=1", cnt_a); end
        $display("lat1: load rd=5 then rs1=5 -> cnt=%0d", cnt_a);
    endtask

    task automatic test_lat3();
        do_reset();
        drive_load(5'd7);
        step();
        drive_use(1, 5'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_b !== STALL) begin errors++; $display("FAIL lat3_stall%0d got=%b exp=%b", i, ctl_b, STALL); end
            step();
        end
        checks++;
        if (ctl_b !== IDLE) begin errors++; $display("FAIL lat3_release got=%b exp=%b", ctl_b, IDLE); end
        checks++;
        if (cnt_b !== 16'd3) begin errors++; $display("FAIL lat3_cnt got=%0d exp=3", cnt_b); end
        $display("lat3: immediate use -> cnt=%0d", cnt_b);

        do_reset();
        drive_load(5'd7);
        step();
        set_idle();
        #1;
        checks++;
        if (ctl_b !== IDLE) begin errors++; $display("FAIL lat3_gap got=%b exp=%b", ctl_b, IDLE); end
        step();
        drive_use(1, 5'd7, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ctl_b !== STALL) begin errors++; $display("FAIL lat3_m2_stall%0d got=%b exp=%b", i, ctl_b, STALL); end
            step();
        end
        checks++;
        if (ctl_b !== IDLE) begin errors++; $display("FAIL lat3_m2_release got=%b exp=%b", ctl_b, IDLE); end
        checks++;
        if (cnt_b !== 16'd2) begin errors++; $display("FAIL lat3_m2_cnt got=%0d exp=2", cnt_b); end
        $display("lat3: use two cycles after load -> cnt=%0d", cnt_b);
    endtask

    task automatic test_x0_and_valid();
        do_reset();
        drive_load(5'd0);
        step();
        drive_use(0, 5'd0, 1'b1);
        checks++;
        if (ctl_a !== IDLE) begin errors++; $display("FAIL x0_no_hazard got=%b exp=%b", ctl_a, IDLE); end
        step();
        drive_load(5'd5);
        step();
        drive_use(0, 5'd5, 1'b0);
        checks++;
        if (ctl_a !== IDLE) begin errors++; $display("FAIL invalid_src got=%b exp=%b", ctl_a, IDLE); end
        drive_use(1, 5'd6, 1'b1);
        checks++;
        if (ctl_a !== IDLE) begin errors++; $display("FAIL other_reg got=%b exp=%b", ctl_a, IDLE); end
        step();
        checks++;
        if (cnt_a !== 16'd0) begin errors++; $display("FAIL x0_cnt got=%0d exp=0", cnt_a); end
        $display("x0/valid: cnt=%0d", cnt_a);
    endtask

    task automatic test_mem_busy();
        do_reset();
        drive_load(5'd7);
        step();
        drive_use(1, 5'd7, 1'b1);
        mem_busy_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl_b !== FREEZE) begin errors++; $display("FAIL busy_freeze%0d got=%b exp=%b", i, ctl_b, FREEZE); end
            step();
            checks++;
            if (cnt_b !== 16'd0) begin errors++; $display("FAIL busy_cnt%0d got=%0d exp=0", i, cnt_b); end
        end
        mem_busy_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_b !== STALL) begin errors++; $display("FAIL busy_resume%0d got=%b exp=%b", i, ctl_b, STALL); end
            step();
            checks++;
            if (cnt_b !== 16'(i + 1)) begin errors++; $display("FAIL busy_resume_cnt%0d got=%0d exp=%0d", i, cnt_b, i + 1); end
        end
        checks++;
        if (ctl_b !== IDLE) begin errors++; $display("FAIL busy_release got=%b exp=%b", ctl_b, IDLE); end
        $display("mem_busy: 4 frozen cycles then cnt=%0d", cnt_b);
    endtask

    task automatic test_branch();
        do_reset();
        drive_load(5'd5);
        step();
        drive_use(0, 5'd5, 1'b1);
        branch_flush_i = 1'b1;
        #1;
        checks++;
        if (ctl_a !== STALL) begin errors++; $display("FAIL branch_vs_hazard got=%b exp=%b", ctl_a, STALL); end
        step();
        checks++;
        if (ctl_a !== FLUSH) begin errors++; $display("FAIL branch_flush got=%b exp=%b", ctl_a, FLUSH); end
        step();
        branch_flush_i = 1'b0;
        #1;
        checks++;
        if (ctl_a !== IDLE) begin errors++; $display("FAIL branch_after got=%b exp=%b", ctl_a, IDLE); end
        $display("branch: hazard first, flush next cycle, cnt=%0d", cnt_a);
    endtask

    task automatic test_saturate_and_reset();
        logic [3:0] exp_cnt;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            drive_load(5'd5);
            step();
            drive_use(0, 5'd5, 1'b1);
            step();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (cnt_c !== exp_cnt) begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, cnt_c, exp_cnt); end
        end
        $display("saturate: after 17 stalls cnt=%0d", cnt_c);
        drive_load(5'd5);
        step();
        drive_use(0, 5'd5, 1'b1);
        checks++;
        if (ctl_c !== STALL) begin errors++; $display("FAIL sat_prestall got=%b exp=%b", ctl_c, STALL); end
        rst_i = 1'b0;
        #1;
        checks++;
        if (ctl_c !== IDLE) begin errors++; $display("FAIL midstall_rst_ctl got=%b exp=%b", ctl_c, IDLE); end
        checks++;
        if (cnt_c !== 4'd0) begin errors++; $display("FAIL midstall_rst_cnt got=%0d exp=0", cnt_c); end
        step();
        rst_i = 1'b1;
        #1;
        checks++;
        if (ctl_c !== IDLE) begin errors++; $display("FAIL post_rst_empty got=%b exp=%b", ctl_c, IDLE); end
        step();
        checks++;
        if (cnt_c !== 4'd0) begin errors++; $display("FAIL post_rst_cnt got=%0d exp=0", cnt_c); end
        $display("reset mid-stall: ctl=%b cnt=%0d", ctl_c, cnt_c);
    endtask

    initial begin
        set_idle();
        rst_i = 1'b0;
        step();
        test_reset();
        test_lat1();
        test_lat3();
        test_x0_and_valid();
        test_mem_busy();
        test_branch();
        test_saturate_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL provide parameter NUM_SRC, default 2, number of source-operand channels checked in IF/ID.
REQ-003 SHALL provide parameter LOAD_LAT, default 1, range 1..4, cycles after EX entry before load data is forwardable.
REQ-004 SHALL provide parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_memread_i  in  1  instruction leaving ID is a load.
- id_rd_i  in  REG_ADDR_W  destination of instruction leaving ID.
- ifid_rs_addr_i  in  NUM_SRC*REG_ADDR_W  packed IF/ID source addresses, channel k at bits [k*REG_ADDR_W +: REG_ADDR_W].
- ifid_rs_valid_i  in  NUM_SRC  per-channel "source actually read".
- mem_busy_i  in  1  data memory/cache not ready; freeze pipeline.
- branch_flush_i  in  1  taken branch resolved in ID; kill IF/ID.
- pc_write_o  out  1  PC may update.
- stall_o  out  1  hold IF/ID register.
- noop_o  out  1  inject bubble into ID/EX.
- flush_o  out  1  clear IF/ID register.
- stall_cnt_o  out  CNT_W  load-use stall cycles counted.

Function
REQ-006 SHALL keep a scoreboard shift register of LOAD_LAT entries {valid, rd}; entry 0 = instruction in EX.
REQ-007 SHALL raise hazard when any channel k has ifid_rs_valid_i[k]=1, address != 0, and address equal to rd of any valid entry.
REQ-008 Register 0 SHALL never create a hazard or a valid entry.
REQ-009 Outputs SHALL be combinational from scoreboard state and current inputs; no added latency.
REQ-010 Priority SHALL be mem_busy_i > hazard > branch_flush_i.
REQ-011 mem_busy_i=1: pc_write_o=0, stall_o=1, noop_o=0, flush_o=0; scoreboard and counter frozen.
REQ-012 Hazard, mem_busy_i=0: pc_write_o=0, stall_o=1, noop_o=1, flush_o=0; bubble (valid=0) shifts into entry 0; counter increments.
REQ-013 branch_flush_i=1, no hazard, not busy: pc_write_o=1, stall_o=0, noop_o=0, flush_o=1; ID instruction still shifts in normally.
REQ-014 Otherwise idle: pc_write_o=1, stall_o=0, noop_o=0, flush_o=0; entry 0 loads {id_memread_i && id_rd_i!=0, id_rd_i}.
REQ-015 Every non-frozen cycle entries SHALL shift by one; the oldest entry is discarded.
REQ-016 stall_cnt_o SHALL saturate at all-ones, never wrap.
REQ-017 With LOAD_LAT=1, behaviour SHALL equal a single-stage load-use detector (one bubble per dependent load).
REQ-018 With LOAD_LAT=N, a use immediately after a load SHALL stall exactly N cycles; a use M cycles later (M<=N) stalls N-M+1 cycles.

Reset
REQ-019 While rst_i=0: all scoreboard entries invalid, stall_cnt_o=0, pc_write_o=1, stall_o=0, noop_o=0, flush_o=0 regardless of other inputs.
REQ-020 Assertion mid-stall SHALL abort the stall immediately; first cycle after release behaves as empty scoreboard.

Structure
REQ-021 Shared package SHALL hold REG_ADDR_W default, x0 constant, and the scoreboard entry struct.
REQ-022 One sub-module, hazard_match, SHALL compare one source channel against all entries; instantiated NUM_SRC times.

Verification
REQ-023 LOAD_LAT=1: load rd=5, next rs1=5 valid -> one cycle pc_write_o=0, stall_o=1, noop_o=1; stall_cnt_o=1.
REQ-024 LOAD_LAT=3: load rd=7, next rs2=7 -> 3 stall cycles; instruction one cycle later -> 3 stall cycles total from load; cnt=3.
REQ-025 Load rd=0 then rs1=0; or rs1=5 with ifid_rs_valid_i[0]=0 -> no stall.
REQ-026 mem_busy_i=1 for 4 cycles during pending hazard -> freeze (noop_o=0) 4 cycles, then hazard stall resumes with counts unchanged during freeze.
REQ-027 Hazard and branch_flush_i same cycle -> flush_o=0, stall taken; flush honoured on the following non-hazard cycle.
REQ-028 Force stall_cnt_o to all-ones via CNT_W=4 (16 stalls) -> stays 15; rst_i low mid-stall -> outputs idle, counter 0 asynchronously.
